// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone-to-SDRAM-controller slave.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'd0;
  localparam logic [2:0] CTI_EOB     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_RELEASE
  } state_e;

  // Wishbone sel bits map one-to-one onto controller byte enables.
  function automatic logic [3:0] sel_to_mask(input logic [3:0] sel);
    return sel;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating request-age counter; flags the cycle in which the count reaches the limit.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_c_o = enable_i && (cnt_d == CNT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wishbone_sdram_slave.sv
// Wishbone B4 classic slave turning single-beat cycles into one SDRAM controller request,
// with an address-window check and a response timeout.
module wishbone_sdram_slave
  import wb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [29:0]               addr,
  input  logic [31:0]               data_write,
  input  logic [3:0]                sel,
  input  logic                      cyc,
  input  logic                      stb,
  input  logic                      we,
  input  logic [2:0]                cti,
  input  logic [1:0]                bte,
  output logic                      ack,
  output logic                      err,
  output logic [31:0]               data_read,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_mask,
  output logic                      mem_wr,
  output logic                      mem_rd,
  input  logic                      mem_busy,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_rdata_valid,
  input  logic                      mem_wr_done
);

  state_e                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [31:0]               data_read_q, data_read_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]               mem_wdata_q, mem_wdata_d;
  logic [3:0]                mem_mask_q, mem_mask_d;
  logic                      mem_wr_q, mem_wr_d;
  logic                      mem_rd_q, mem_rd_d;
  logic                      we_q, we_d;
  logic                      abort_q, abort_d;

  logic in_flight_c;
  logic expired_c;
  logic in_window_c;
  logic complete_c;
  logic abort_now_c;
  logic unused_cti_c;

  // Every cti value is served as a single classic beat; bte carries no meaning here.
  assign unused_cti_c = ^{bte, (cti == CTI_EOB), (cti == CTI_CLASSIC)};

  assign in_flight_c = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign in_window_c = ((addr >> MEM_ADDR_WIDTH) == 30'd0);
  assign complete_c  = we_q ? mem_wr_done : mem_rdata_valid;
  assign abort_now_c = abort_q || !cyc;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (clk_sys),
    .reset_i    (reset),
    .clear_i    (!in_flight_c),
    .enable_i   (in_flight_c),
    .expired_c_o(expired_c)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    data_read_d = data_read_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    we_d        = we_q;
    abort_d     = abort_q;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cyc && stb) begin
          mem_addr_d  = addr[MEM_ADDR_WIDTH-1:0];
          mem_wdata_d = data_write;
          mem_mask_d  = sel_to_mask(sel);
          we_d        = we;
          if (!in_window_c) begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end else if (we && (sel == 4'h0)) begin
            ack_d   = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            mem_wr_d = we;
            mem_rd_d = !we;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        abort_d = abort_now_c;
        if (expired_c) begin
          mem_wr_d = 1'b0;
          mem_rd_d = 1'b0;
          err_d    = !abort_now_c;
          state_d  = abort_now_c ? ST_IDLE : ST_RELEASE;
        end else if (!mem_busy) begin
          mem_wr_d = 1'b0;
          mem_rd_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        abort_d = abort_now_c;
        // A completion landing on the expiry cycle still counts as success.
        if (complete_c) begin
          if (abort_now_c) begin
            state_d = ST_IDLE;
          end else begin
            ack_d   = 1'b1;
            state_d = ST_RESP;
            if (!we_q) begin
              data_read_d = mem_rdata;
            end
          end
        end else if (expired_c) begin
          err_d   = !abort_now_c;
          state_d = abort_now_c ? ST_IDLE : ST_RELEASE;
        end
      end
      ST_RESP: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!stb) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      data_read_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      data_read_q <= data_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      we_q        <= we_d;
      abort_q     <= abort_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign data_read = data_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mask  = mem_mask_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_wishbone_sdram_slave.sv
// Self-checking bench for wishbone_sdram_slave: vector table, hand sequences and a random run.
module tb_wishbone_sdram_slave;

  localparam int unsigned TMO     = 8;
  localparam int          CYC_WIN = 24;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [31:0] data_write;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err;
  logic [31:0] data_read;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr, mem_rd;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_wr_done;

  always #5 clk_sys = ~clk_sys;

  wishbone_sdram_slave #(
    .MEM_ADDR_WIDTH(24),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .addr           (addr),
    .data_write     (data_write),
    .sel            (sel),
    .cyc            (cyc),
    .stb            (stb),
    .we             (we),
    .cti            (cti),
    .bte            (bte),
    .ack            (ack),
    .err            (err),
    .data_read      (data_read),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_mask       (mem_mask),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_busy       (mem_busy),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_wr_done    (mem_wr_done)
  );

  // One master cycle plus controller behaviour, with the expected response.
  // Cycle 0 is the cycle stb is first presented; busy = cycles the controller refuses,
  // lat = cycles from accept to the completion strobe; exp_* cycle 0 means "never".
  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          busy;
    int          lat;
    logic        respond;
    logic [31:0] rdata;
    int          hold;
    int          exp_ack;
    int          exp_err;
    int          exp_req;
    logic [31:0] exp_dr;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] dr_model;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we_v, input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int busy, input int lat,
                              input logic resp, input logic [31:0] rd, input int hold,
                              input int ea, input int ee, input int er, input logic [31:0] edr);
    vec_t v;
    v.we = we_v; v.addr = a; v.data = d; v.sel = s; v.busy = busy; v.lat = lat;
    v.respond = resp; v.rdata = rd; v.hold = hold;
    v.exp_ack = ea; v.exp_err = ee; v.exp_req = er; v.exp_dr = edr;
    return v;
  endfunction

  // Reference: response cycle from the window / sel rules, accept and completion arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] dr_prev);
    vec_t r;
    int   a;
    int   c;
    r = v;
    r.exp_ack = 0; r.exp_err = 0; r.exp_req = 0; r.exp_dr = dr_prev;
    if ((v.addr >> 24) != 30'd0) begin
      r.exp_err = 1;
    end else if (v.we && (v.sel == 4'h0)) begin
      r.exp_ack = 1;
    end else begin
      a = v.busy + 1;
      c = a + v.lat;
      if (v.respond && (c <= int'(TMO))) begin
        r.exp_ack = c + 1;
        r.exp_req = a;
        if (!v.we) r.exp_dr = v.rdata;
      end else begin
        r.exp_err = int'(TMO) + 1;
        r.exp_req = (a < int'(TMO)) ? a : int'(TMO);
      end
    end
    return r;
  endfunction

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    mem_busy = 1'b0; mem_rdata_valid = 1'b0; mem_wr_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int first_ack = 0, first_err = 0, n_ack = 0, n_err = 0, n_both = 0;
    int n_req = 0, n_wrong = 0, n_bad = 0, resp = 0;
    int done_at;
    logic req, wrong;
    done_at    = v.busy + 1 + v.lat;
    addr       = v.addr; data_write = v.data; sel = v.sel; we = v.we;
    cti        = 3'($urandom); bte = 2'($urandom);
    mem_rdata  = v.rdata;
    cyc        = 1'b1; stb = 1'b1;
    for (int k = 1; k <= CYC_WIN; k++) begin
      @(posedge clk_sys); #1;
      if (ack) begin n_ack++; if (first_ack == 0) first_ack = k; end
      if (err) begin n_err++; if (first_err == 0) first_err = k; end
      if (ack && err) n_both++;
      req   = v.we ? mem_wr : mem_rd;
      wrong = v.we ? mem_rd : mem_wr;
      if (req) begin
        n_req++;
        if (mem_addr !== v.addr[23:0] || mem_mask !== v.sel || (v.we && mem_wdata !== v.data))
          n_bad++;
      end
      if (wrong) n_wrong++;
      if ((ack || err) && resp == 0) resp = k;
      if (resp != 0 && k >= resp + 1 + v.hold) begin cyc = 1'b0; stb = 1'b0; end
      mem_busy        = (k <= v.busy);
      mem_rdata_valid = v.respond && !v.we && (k == done_at);
      mem_wr_done     = v.respond && v.we && (k == done_at);
    end
    idle_bus();
    check($sformatf("%s_ack_count", tag), 32'(n_ack), (v.exp_ack != 0) ? 32'd1 : 32'd0);
    check($sformatf("%s_ack_cycle", tag), 32'(first_ack), 32'(v.exp_ack));
    check($sformatf("%s_err_count", tag), 32'(n_err), (v.exp_err != 0) ? 32'd1 : 32'd0);
    check($sformatf("%s_err_cycle", tag), 32'(first_err), 32'(v.exp_err));
    check($sformatf("%s_ack_err_overlap", tag), 32'(n_both), 32'd0);
    check($sformatf("%s_req_cycles", tag), 32'(n_req), 32'(v.exp_req));
    check($sformatf("%s_wrong_req_cycles", tag), 32'(n_wrong), 32'd0);
    check($sformatf("%s_req_payload_bad", tag), 32'(n_bad), 32'd0);
    check($sformatf("%s_data_read", tag), data_read, v.exp_dr);
  endtask

  initial begin
    vec_t v;
    int   n_ack, n_err, n_rd;

    reset = 1'b1; idle_bus();
    addr = '0; data_write = '0; sel = '0; cti = '0; bte = '0; mem_rdata = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data_read", data_read, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_mask", 32'(mem_mask), 32'd0);
    reset = 1'b0;
    dr_model = 32'd0;
    @(posedge clk_sys); #1;

    //         we  addr            data          sel   bsy lat rsp rdata         hold ack err req data_read
    vecs.push_back(mk(0, 30'h10,        32'h0,        4'hF, 0,  2, 1, 32'hDEADBEEF, 0, 4, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 30'h20,        32'h12345678, 4'hF, 5,  1, 1, 32'h0,        0, 8, 0, 6, 32'hDEADBEEF));
    vecs.push_back(mk(0, 30'h0100_0000, 32'h0,        4'hF, 0,  1, 0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 30'h40,        32'h0,        4'hF, 0, 11, 1, 32'hBAD0BAD0, 0, 0, 9, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 30'h44,        32'h0,        4'hF, 0,  7, 1, 32'hA5A55A5A, 0, 9, 0, 1, 32'hA5A55A5A));
    vecs.push_back(mk(0, 30'h48,        32'h0,        4'hF, 0,  8, 1, 32'h11111111, 0, 0, 9, 1, 32'hA5A55A5A));
    vecs.push_back(mk(1, 30'h50,        32'hFFFFFFFF, 4'h0, 0,  1, 1, 32'h0,        0, 1, 0, 0, 32'hA5A55A5A));
    vecs.push_back(mk(1, 30'h54,        32'hCAFEF00D, 4'h5, 0,  1, 1, 32'h0,        0, 3, 0, 1, 32'hA5A55A5A));
    vecs.push_back(mk(0, 30'h00FF_FFFF, 32'h0,        4'hF, 0,  1, 1, 32'h0F0F0F0F, 0, 3, 0, 1, 32'h0F0F0F0F));
    vecs.push_back(mk(0, 30'h3FFF_FFFF, 32'h0,        4'hF, 0,  1, 1, 32'h99999999, 0, 0, 1, 0, 32'h0F0F0F0F));
    vecs.push_back(mk(0, 30'h60,        32'h0,        4'hF, 7,  1, 1, 32'h22222222, 0, 0, 9, 8, 32'h0F0F0F0F));
    vecs.push_back(mk(1, 30'h64,        32'h55AA55AA, 4'hF, 20, 1, 1, 32'h0,        0, 0, 9, 8, 32'h0F0F0F0F));
    vecs.push_back(mk(0, 30'h70,        32'h0,        4'h3, 0,  1, 1, 32'h13579BDF, 1, 3, 0, 1, 32'h13579BDF));
    vecs.push_back(mk(1, 30'h74,        32'h0BADF00D, 4'hC, 0,  1, 1, 32'h0,        0, 3, 0, 1, 32'h13579BDF));

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      dr_model = vecs[i].exp_dr;
    end

    // Reset while waiting for read data abandons the request and clears the outputs.
    addr = 30'h10; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk_sys); #1;
    check("rstwait_issue_rd", 32'(mem_rd), 32'd1);
    mem_busy = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("rstwait_ack", 32'(ack), 32'd0);
    check("rstwait_err", 32'(err), 32'd0);
    check("rstwait_mem_rd", 32'(mem_rd), 32'd0);
    check("rstwait_data_read", data_read, 32'd0);
    reset = 1'b0; idle_bus();
    repeat (2) @(posedge clk_sys);
    #1;
    dr_model = 32'd0;
    v = model(mk(0, 30'h4, 32'h0, 4'hF, 1, 2, 1, 32'h600DCAFE, 0, 0, 0, 0, 32'h0), dr_model);
    run_vec(v, "post_reset_read");
    dr_model = v.exp_dr;

    // Master abandons the cycle while the request is pending: memory side finishes, no response.
    n_ack = 0; n_err = 0; n_rd = 0;
    addr = 30'h80; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    mem_rdata = 32'h77777777;
    for (int k = 1; k <= CYC_WIN; k++) begin
      @(posedge clk_sys); #1;
      if (ack) n_ack++;
      if (err) n_err++;
      if (mem_rd) n_rd++;
      if (k == 2) begin cyc = 1'b0; stb = 1'b0; end
      mem_busy        = (k <= 2);
      mem_rdata_valid = (k == 5);
    end
    idle_bus();
    check("abort_ack", 32'(n_ack), 32'd0);
    check("abort_err", 32'(n_err), 32'd0);
    check("abort_rd_cycles", 32'(n_rd), 32'd3);
    check("abort_data_read", data_read, dr_model);

    for (int i = 0; i < 40; i++) begin
      v.we      = 1'($urandom_range(0, 1));
      v.addr    = ($urandom_range(0, 9) == 0) ? {6'($urandom_range(1, 63)), 24'($urandom)}
                                              : {6'd0, 24'($urandom)};
      v.data    = $urandom;
      v.sel     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      v.busy    = int'($urandom_range(0, 9));
      v.lat     = int'($urandom_range(1, 9));
      v.respond = ($urandom_range(0, 4) != 0);
      v.rdata   = $urandom;
      v.hold    = int'($urandom_range(0, 2));
      v = model(v, dr_model);
      run_vec(v, $sformatf("rnd%0d", i));
      dr_model = v.exp_dr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
